oversampling_phase_tracker: RTL and testbench
=============================================

OVERSAMPLING_PHASE_TRACKER -- requirements
Module: oversampling_phase_tracker

Interface
REQ-001 Parameter WINDOW, default 64, samples per majority measurement; power of two, 8..1024.
REQ-002 Parameter MAX_STEPS, default 448, fine-phase steps allowed in the initial sweep before failure.
REQ-003 Parameter SETTLE, default 16, idle cycles after each phase_shift_done before sampling resumes.
REQ-004 Parameter TIMEOUT, default 255, maximum cycles from phase_shift_en to phase_shift_done.
REQ-005 Parameter TRACK_INTERVAL, default 4096, cycles between tracking measurements.
REQ-006 clk  in  1  sole clock, also the PLL phase-shift clock; 312.5 MHz nominal.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 pll_lock  in  1  PLL locked, already synchronous to clk.
REQ-009 start  in  1  single-cycle request to begin alignment.
REQ-010 sample  in  1  phase-detector bit (fabric 625 MHz clock sampled by the IO clock), synchronous to clk.
REQ-011 phase_shift_en  out  1  single-cycle PLL fine-shift request.
REQ-012 phase_shift_inc  out  1  direction: 1 increment, 0 decrement; valid with phase_shift_en.
REQ-013 phase_shift_done  in  1  single-cycle PLL completion.
REQ-014 busy  out  1  sweep in progress.
REQ-015 done  out  1  aligned; held until pll_lock loss, reset or a new start.
REQ-016 fail  out  1  sweep or timeout failure; sticky until start or reset.
REQ-017 phase_offset  out  $clog2(MAX_STEPS)+2  signed net steps applied since the last PLL lock.

Function
REQ-018 FSM states: IDLE, WAIT_LOCK, MEASURE, STEP, WAIT_DONE, SETTLE, LOCKED, FAIL.
REQ-019 IDLE -> WAIT_LOCK on start; clear done, fail and phase_offset. start outside IDLE, LOCKED and FAIL is ignored.
REQ-020 WAIT_LOCK -> MEASURE on the first cycle pll_lock=1; the first measurement latches reference level L0.
REQ-021 MEASURE counts ones over exactly WINDOW consecutive cycles; level = (ones >= WINDOW/2), so a tie reads 1; the counter is $clog2(WINDOW+1) bits.
REQ-022 Sweep: if level==L0 -> STEP with inc=1; else set done, go to LOCKED, target T=level.
REQ-023 STEP asserts phase_shift_en for exactly one cycle, then goes to WAIT_DONE; phase_offset updates by +/-1 in that cycle.
REQ-024 WAIT_DONE -> SETTLE on phase_shift_done; if TIMEOUT cycles elapse without it -> FAIL.
REQ-025 SETTLE waits SETTLE cycles, then -> MEASURE; samples taken during STEP, WAIT_DONE and SETTLE are discarded.
REQ-026 If phase_offset reaches MAX_STEPS with no level change -> FAIL; no further step is issued.
REQ-027 A phase_shift_done arriving outside WAIT_DONE is ignored.
REQ-028 pll_lock falling in any state other than IDLE or FAIL -> WAIT_LOCK; clear done and phase_offset; abandon any in-flight step.
REQ-029 busy=1 in WAIT_LOCK, MEASURE, STEP, WAIT_DONE and SETTLE during the sweep; busy=0 elsewhere.
REQ-030 FAIL holds fail=1 and no shifts are issued; start -> WAIT_LOCK.
REQ-031 LOCKED with tracking compiled out: terminal; start -> WAIT_LOCK re-sweep.

Reset
REQ-032 On rst_n=0: state IDLE; phase_shift_en, phase_shift_inc, busy, done and fail = 0; phase_offset = 0; all counters = 0.
REQ-033 The first state change happens no earlier than the first clk edge after rst_n deasserts.

Configuration
REQ-034 Macro OVERSAMPLING_PHASE_TRACKING_EN compiled in: LOCKED re-measures every TRACK_INTERVAL cycles.
REQ-035 Tracking correction: level==T -> one decrement step; else one increment step. Each step uses the STEP/WAIT_DONE/SETTLE path, then returns to LOCKED with done held 1.
REQ-036 In tracking, |phase_offset| exceeding MAX_STEPS or a timeout -> FAIL with done=0.
REQ-037 Macro absent: REQ-031 applies and the tracking interval counter is not synthesised.

Structure
REQ-038 The state enum and the offset width function belong in shared package oversampling_pkg.
REQ-039 Sub-module oversampling_majority_window (windowed ones counter with a clear input) is instantiated once.

Verification
REQ-040 sample=0 for offsets <37 and 1 from 37 on, WINDOW=64 -> 37 single-cycle inc pulses, done=1, phase_offset=37, fail=0.
REQ-041 sample held constant, MAX_STEPS=448 -> exactly 448 pulses, then fail=1, busy=0, done=0.
REQ-042 phase_shift_done suppressed on the 5th step -> fail=1 exactly TIMEOUT=255 cycles after that phase_shift_en.
REQ-043 pll_lock dropped for 10 cycles mid-sweep at offset 20 -> phase_offset=0, done=0, sweep restarts once lock returns.
REQ-044 Sample ones-count exactly 32 of 64 -> level 1.
REQ-045 With OVERSAMPLING_PHASE_TRACKING_EN: after lock at 37, edge moved to 39 -> offset oscillates within 38..40, done stays 1.

Source files
------------

// File: rtl/oversampling_pkg.sv
// oversampling_pkg: shared FSM state type and offset-width helper for the
// oversampling phase tracker and its sub-blocks.
package oversampling_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_MEASURE   = 3'd2,
        ST_STEP      = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_SETTLE    = 3'd5,
        ST_LOCKED    = 3'd6,
        ST_FAIL      = 3'd7
    } state_e;

    // Signed offset needs magnitude bits plus sign plus one headroom bit
    // so that one step past MAX_STEPS is still representable.
    function automatic int unsigned offset_w(input int unsigned max_steps);
        return $clog2(max_steps) + 2;
    endfunction

endpackage

// File: rtl/oversampling_majority_window.sv
// oversampling_majority_window: counts ones over WINDOW consecutive
// enabled cycles. Ports: clk, rst_n, clr (hold empty), sample,
// last (final sample of the window this cycle), ones (total incl. sample).
module oversampling_majority_window #(
    parameter int unsigned WINDOW = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         sample,
    output logic                         last,
    output logic [$clog2(WINDOW+1)-1:0]  ones
);

    localparam int unsigned IW = $clog2(WINDOW);
    localparam int unsigned WW = $clog2(WINDOW + 1);

    logic [IW-1:0] idx_q, idx_d;
    logic [WW-1:0] ones_q, ones_d;

    assign last = !clr && (idx_q == IW'(WINDOW - 1));
    assign ones = ones_q + WW'(sample);

    always_comb begin
        idx_d  = idx_q + 1'b1;
        ones_d = ones;
        if (clr || last) begin
            idx_d  = '0;
            ones_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            ones_q <= '0;
        end else begin
            idx_q  <= idx_d;
            ones_q <= ones_d;
        end
    end

endmodule

// File: rtl/oversampling_phase_tracker.sv
// oversampling_phase_tracker: sweeps the PLL fine phase until the majority
// level of the phase-detector bit flips, then reports alignment.
// Ports: clk, rst_n, pll_lock, start, sample, phase_shift_done in;
// phase_shift_en/inc, busy, done, fail, phase_offset out.
// Macro OVERSAMPLING_PHASE_TRACKING_EN adds periodic re-measurement
// and one-step correction while locked.
module oversampling_phase_tracker
    import oversampling_pkg::*;
#(
    parameter int unsigned WINDOW         = 64,
    parameter int unsigned MAX_STEPS      = 448,
    parameter int unsigned SETTLE         = 16,
    parameter int unsigned TIMEOUT        = 255,
    parameter int unsigned TRACK_INTERVAL = 4096
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 pll_lock,
    input  logic                                 start,
    input  logic                                 sample,
    output logic                                 phase_shift_en,
    output logic                                 phase_shift_inc,
    input  logic                                 phase_shift_done,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 fail,
    output logic signed [offset_w(MAX_STEPS)-1:0] phase_offset
);

    localparam int unsigned OW = offset_w(MAX_STEPS);
    localparam int unsigned WW = $clog2(WINDOW + 1);
`ifdef OVERSAMPLING_PHASE_TRACKING_EN
    localparam int unsigned TRK_SPAN = TRACK_INTERVAL;
`else
    // Without tracking the shared counter never spans an interval.
    localparam int unsigned TRK_SPAN =
        (TRACK_INTERVAL < 1) ? TRACK_INTERVAL : 1;
`endif
    localparam int unsigned CMAX0 = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
    localparam int unsigned CMAX  = (CMAX0 > TRK_SPAN) ? CMAX0 : TRK_SPAN;
    localparam int unsigned CW    = $clog2(CMAX + 1);
    localparam logic signed [OW-1:0] OFS_MAX = OW'(MAX_STEPS);

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic signed [OW-1:0]  ofs_q, ofs_d;
    logic                  inc_q, inc_d;
    logic                  l0_q, l0_d;
    logic                  ref_q, ref_d;
    logic                  trk_q, trk_d;
    logic                  win_clr, win_last, level, lock_loss;
    logic [WW-1:0]         win_ones;
`ifdef OVERSAMPLING_PHASE_TRACKING_EN
    logic                  tgt_q, tgt_d;
    logic                  trk_inc;
    logic signed [OW-1:0]  ofs_nxt;
    logic [OW-1:0]         ofs_abs;
`endif

    assign win_clr = (state_q != ST_MEASURE);

    oversampling_majority_window #(
        .WINDOW (WINDOW)
    ) u_window (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (win_clr),
        .sample (sample),
        .last   (win_last),
        .ones   (win_ones)
    );

    // Tie (exactly half ones) reads as 1.
    assign level     = (win_ones >= WW'(WINDOW / 2));
    assign lock_loss = !pll_lock && (state_q != ST_IDLE)
                       && (state_q != ST_FAIL);

`ifdef OVERSAMPLING_PHASE_TRACKING_EN
    // Still on the target side of the edge: back off; else push forward.
    assign trk_inc = (level != tgt_q);
    assign ofs_nxt = trk_inc ? ofs_q + OW'(1) : ofs_q - OW'(1);
    assign ofs_abs = ofs_nxt[OW-1] ? $unsigned(-ofs_nxt)
                                   : $unsigned(ofs_nxt);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ofs_d   = ofs_q;
        inc_d   = inc_q;
        l0_d    = l0_q;
        ref_d   = ref_q;
        trk_d   = trk_q;
`ifdef OVERSAMPLING_PHASE_TRACKING_EN
        tgt_d   = tgt_q;
`endif
        unique case (state_q)
            ST_IDLE, ST_FAIL, ST_LOCKED: begin
                if (start) begin
                    state_d = ST_WAIT_LOCK;
                    ofs_d   = '0;
                    ref_d   = 1'b0;
                    cnt_d   = '0;
                end
`ifdef OVERSAMPLING_PHASE_TRACKING_EN
                else if (state_q == ST_LOCKED) begin
                    if (cnt_q >= CW'(TRACK_INTERVAL - 1)) begin
                        state_d = ST_MEASURE;
                        trk_d   = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif
            end
            ST_WAIT_LOCK: begin
                if (pll_lock) state_d = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (win_last) begin
`ifdef OVERSAMPLING_PHASE_TRACKING_EN
                    if (trk_q) begin
                        if (ofs_abs > OW'(MAX_STEPS)) begin
                            state_d = ST_FAIL;
                            trk_d   = 1'b0;
                        end else begin
                            state_d = ST_STEP;
                            inc_d   = trk_inc;
                            ofs_d   = ofs_nxt;
                        end
                    end else
`endif
                    begin
                        // First window of a sweep defines the reference.
                        if (!ref_q) begin
                            l0_d  = level;
                            ref_d = 1'b1;
                        end
                        if (ref_q && (level != l0_q)) begin
                            state_d = ST_LOCKED;
                            cnt_d   = '0;
`ifdef OVERSAMPLING_PHASE_TRACKING_EN
                            tgt_d   = level;
`endif
                        end else if (ofs_q == OFS_MAX) begin
                            state_d = ST_FAIL;
                        end else begin
                            state_d = ST_STEP;
                            inc_d   = 1'b1;
                            ofs_d   = ofs_q + OW'(1);
                        end
                    end
                end
            end
            ST_STEP: begin
                state_d = ST_WAIT_DONE;
                cnt_d   = CW'(1);
            end
            ST_WAIT_DONE: begin
                if (phase_shift_done) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end else if (cnt_q >= CW'(TIMEOUT - 1)) begin
                    state_d = ST_FAIL;
                    trk_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SETTLE: begin
                if (cnt_q >= CW'(SETTLE - 1)) begin
                    cnt_d   = '0;
                    state_d = trk_q ? ST_LOCKED : ST_MEASURE;
                    trk_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A relock restarts the sweep from phase zero.
        if (lock_loss) begin
            state_d = ST_WAIT_LOCK;
            ofs_d   = '0;
            ref_d   = 1'b0;
            trk_d   = 1'b0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ofs_q   <= '0;
            inc_q   <= 1'b0;
            l0_q    <= 1'b0;
            ref_q   <= 1'b0;
            trk_q   <= 1'b0;
`ifdef OVERSAMPLING_PHASE_TRACKING_EN
            tgt_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ofs_q   <= ofs_d;
            inc_q   <= inc_d;
            l0_q    <= l0_d;
            ref_q   <= ref_d;
            trk_q   <= trk_d;
`ifdef OVERSAMPLING_PHASE_TRACKING_EN
            tgt_q   <= tgt_d;
`endif
        end
    end

    assign phase_shift_en  = (state_q == ST_STEP);
    assign phase_shift_inc = inc_q;
    assign busy            = !trk_q && (state_q inside {ST_WAIT_LOCK,
                             ST_MEASURE, ST_STEP, ST_WAIT_DONE, ST_SETTLE});
    assign done            = (state_q == ST_LOCKED) || trk_q;
    assign fail            = (state_q == ST_FAIL);
    assign phase_offset    = ofs_q;

endmodule

// File: tb/tb_oversampling_phase_tracker.sv
// tb_oversampling_phase_tracker: randomized bench with a behavioural PLL
// and phase-detector model; edge position decides the expected outcome.
module tb_oversampling_phase_tracker;

    localparam int WINDOW         = 64;
    localparam int MAX_STEPS      = 448;
    localparam int SETTLE         = 16;
    localparam int TIMEOUT        = 255;
    localparam int TRACK_INTERVAL = 512;
    localparam int OW             = $clog2(MAX_STEPS) + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pll_lock = 1'b0;
    logic start = 1'b0;
    logic sample = 1'b0;
    logic phase_shift_done = 1'b0;
    logic phase_shift_en, phase_shift_inc, busy, done, fail;
    logic signed [OW-1:0] phase_offset;

    oversampling_phase_tracker #(
        .WINDOW         (WINDOW),
        .MAX_STEPS      (MAX_STEPS),
        .SETTLE         (SETTLE),
        .TIMEOUT        (TIMEOUT),
        .TRACK_INTERVAL (TRACK_INTERVAL)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pll_lock         (pll_lock),
        .start            (start),
        .sample           (sample),
        .phase_shift_en   (phase_shift_en),
        .phase_shift_inc  (phase_shift_inc),
        .phase_shift_done (phase_shift_done),
        .busy             (busy),
        .done             (done),
        .fail             (fail),
        .phase_offset     (phase_offset)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Scenario knobs (main process only).
    int mode = 0;
    int edge_pos = 37;
    bit noise = 1'b0;
    bit const_val = 1'b0;
    int phase_base = 0;
    int pulse_base = 0;
    int suppress_raw = -1;

    // PLL model state (responder only).
    int raw_phase = 0;
    int raw_pulses = 0;
    // Pulse-width monitor.
    int run_len = 0;
    int wide_cnt = 0;
    bit alt = 1'b0;

    task automatic check(input string tag, input longint got,
                         input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit ideal_level(input int ph, input bit a);
        case (mode)
            0:       return ph >= edge_pos;
            1:       return ph < edge_pos;
            2:       return (ph >= edge_pos) ? a : 1'b0;
            3:       return (ph < edge_pos) ? a : 1'b0;
            default: return const_val;
        endcase
    endfunction

    // Phase detector: level depends on the physical PLL phase.
    always @(negedge clk) begin
        alt = ~alt;
        sample = ideal_level(raw_phase - phase_base, alt)
                 ^ (noise && ($urandom_range(0, 15) == 0));
    end

    always @(negedge clk) begin
        if (phase_shift_en) begin
            run_len = run_len + 1;
            if (run_len == 2) wide_cnt = wide_cnt + 1;
        end else begin
            run_len = 0;
        end
    end

    // PLL: applies each step and answers after a random latency.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && phase_shift_en) begin
                raw_pulses = raw_pulses + 1;
                raw_phase = raw_phase + (phase_shift_inc ? 1 : -1);
                if (raw_pulses != suppress_raw) begin
                    repeat ($urandom_range(1, 6)) @(negedge clk);
                    phase_shift_done = 1'b1;
                    @(negedge clk);
                    phase_shift_done = 1'b0;
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        pll_lock = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_en", phase_shift_en, 0);
        check("rst_inc", phase_shift_inc, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fail", fail, 0);
        check("rst_ofs", phase_offset, 0);
        phase_base = raw_phase;
        pulse_base = raw_pulses;
        suppress_raw = -1;
        pll_lock = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60000; i++) begin
            @(negedge clk);
            if (done || fail) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_en(output bit ok, input int budget);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (phase_shift_en) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic run_sweep(input int m, input int e, input bit nz,
                             input string tag);
        bit ok;
        do_reset();
        mode = m;
        edge_pos = e;
        noise = nz;
        pulse_start();
        check({tag, "_busy"}, busy, 1);
        // A start in the middle of a sweep must be ignored.
        repeat (300) @(negedge clk);
        pulse_start();
        wait_end(ok);
        check({tag, "_end"}, ok, 1);
        check({tag, "_pulses"}, raw_pulses - pulse_base, e);
        check({tag, "_ofs"}, phase_offset, e);
        check({tag, "_done"}, done, 1);
        check({tag, "_fail"}, fail, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        bit ok;
        int n;

        // Random plain edges, both polarities, with detector noise.
        for (int t = 0; t < 4; t++) begin
            run_sweep($urandom_range(0, 1), $urandom_range(5, 60), 1'b1,
                      "rand");
        end
        run_sweep(0, 37, 1'b1, "e37");
        // Exactly half ones per window reads as 1, from either side.
        run_sweep(2, $urandom_range(5, 40), 1'b0, "tie_up");
        run_sweep(3, $urandom_range(5, 40), 1'b0, "tie_dn");

        // No level change anywhere: full sweep then failure.
        do_reset();
        mode = 4;
        const_val = 1'($urandom_range(0, 1));
        noise = 1'b0;
        pulse_start();
        wait_end(ok);
        check("max_end", ok, 1);
        check("max_pulses", raw_pulses - pulse_base, MAX_STEPS);
        check("max_ofs", phase_offset, MAX_STEPS);
        check("max_fail", fail, 1);
        check("max_done", done, 0);
        check("max_busy", busy, 0);
        repeat (200) @(negedge clk);
        check("max_nomore", raw_pulses - pulse_base, MAX_STEPS);
        pulse_start();
        check("restart_fail", fail, 0);
        check("restart_busy", busy, 1);
        check("restart_ofs", phase_offset, 0);

        // Missing phase_shift_done on the fifth step.
        do_reset();
        mode = 0;
        edge_pos = 37;
        suppress_raw = raw_pulses + 5;
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            wait_en(ok, 2000);
            check("to_en", ok, 1);
        end
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            n++;
            if (fail) break;
        end
        check("to_cycles", n, TIMEOUT);
        repeat (20) @(negedge clk);
        check("to_pulses", raw_pulses - pulse_base, 5);
        check("to_fail", fail, 1);
        check("to_done", done, 0);
        check("to_busy", busy, 0);

        // Lock loss at offset 20, then a fresh sweep after relock.
        do_reset();
        mode = 0;
        edge_pos = 37;
        noise = 1'b1;
        pulse_start();
        for (int i = 0; i < 20; i++) wait_en(ok, 2000);
        check("ll_at20", phase_offset, 20);
        @(negedge clk);
        pll_lock = 1'b0;
        phase_base = raw_phase;
        repeat (2) @(negedge clk);
        check("ll_ofs", phase_offset, 0);
        check("ll_done", done, 0);
        check("ll_busy", busy, 1);
        repeat (8) @(negedge clk);
        pulse_base = raw_pulses;
        pll_lock = 1'b1;
        wait_end(ok);
        check("ll_end", ok, 1);
        check("ll_pulses", raw_pulses - pulse_base, 37);
        check("ll_ofs2", phase_offset, 37);
        check("ll_done2", done, 1);

`ifdef OVERSAMPLING_PHASE_TRACKING_EN
        // Locked at 37, edge moves to 39: corrections stay near the edge.
        run_sweep(0, 37, 1'b0, "trk");
        edge_pos = 39;
        for (int i = 0; i < 8; i++) begin
            wait_en(ok, 3 * TRACK_INTERVAL);
            check("trk_en", ok, 1);
            if (!ok) break;
            check("trk_range",
                  (phase_offset >= 38) && (phase_offset <= 40), 1);
            check("trk_done", done, 1);
            check("trk_busy", busy, 0);
        end
`endif

        check("en_width", wide_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
